prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 11 +
 rtl/prog_loader_shift_reg.sv | 29 ++
 rtl/prog_loader.sv | 120 ++++++++++++
 tb/tb_prog_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage : prog_loader_pkg

// File: rtl/prog_loader_shift_reg.sv
// Serial-to-parallel word register: shifts new bits into the LSB, so the
// first bit shifted in ends up as the MSB after WIDTH shifts.
module shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] dout
);

  // Word register; clear takes priority so a new session never inherits stale bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
    end else if (clear) begin
      dout <= '0;
    end else if (shift_en) begin
      if (WIDTH == 1) begin
        dout <= din;
      end else begin
        dout <= {dout[WIDTH-2:0], din};
      end
    end
  end

endmodule : shift_reg

// File: rtl/prog_loader.sv
// Serial instruction loader: assembles MSB-first words from a valid/ready
// bit stream, writes them to consecutive RAM addresses 0..DEPTH-1 and holds
// the core in reset until the whole program is resident.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no program loaded, core held, waiting for start
// ST_SHIFT | accepting serial bits into the word register
// ST_WRITE | one-cycle write strobe of the assembled word
// ST_DONE  | program resident, core released, start triggers a reload
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int BIT_WIDTH  = 4,
  parameter int INST_WIDTH = 8,
  parameter int DEPTH      = 2 ** BIT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ser_in,
  input  logic                  ser_valid,
  output logic                  ser_ready,
  output logic                  wr_en,
  output logic [BIT_WIDTH-1:0]  wr_addr,
  output logic [INST_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done
);

  // Wide enough to hold INST_WIDTH itself after the final increment.
  localparam int CNT_W = $clog2(INST_WIDTH + 1);
  localparam logic [CNT_W-1:0]     LAST_BIT  = CNT_W'(INST_WIDTH - 1);
  localparam logic [BIT_WIDTH-1:0] LAST_ADDR = BIT_WIDTH'(DEPTH - 1);

  loader_state_e        state_q;
  loader_state_e        state_d;
  logic [BIT_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic                 accept;
  logic                 last_bit;
  logic                 session_start;
  logic                 last_addr;

  assign accept        = ser_valid && (state_q == ST_SHIFT);
  assign last_bit      = accept && (bit_cnt_q == LAST_BIT);
  assign session_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_addr     = (addr_q == LAST_ADDR);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (session_start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = ST_WRITE;
      ST_WRITE: state_d = last_addr ? ST_DONE : ST_SHIFT;
      ST_DONE:  if (session_start) state_d = ST_SHIFT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; every term comes straight from the state register.
  always_comb begin
    ser_ready = 1'b0;
    wr_en     = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_SHIFT: ser_ready = 1'b1;
      ST_WRITE: wr_en     = 1'b1;
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  // Address and bit counters; the address only advances on leaving WRITE
  // for another word, so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      bit_cnt_q <= '0;
    end else if (session_start) begin
      addr_q    <= '0;
      bit_cnt_q <= '0;
    end else if (accept) begin
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end else if (state_q == ST_WRITE) begin
      bit_cnt_q <= '0;
      if (!last_addr) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign wr_addr = addr_q;

  shift_reg #(
    .WIDTH (INST_WIDTH)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .clear    (session_start),
    .shift_en (accept),
    .din      (ser_in),
    .dout     (wr_data)
  );

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a DEPTH=4 instance for the main scenarios
// and a DEPTH=2 instance for the short-program case.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       start4 = 1'b0;
  logic       start2 = 1'b0;
  logic       sel = 1'b0;

  logic       rdy4, wen4, hold4, done4;
  logic [1:0] addr4;
  logic [2:0] data4;
  logic       rdy2, wen2, hold2, done2;
  logic [1:0] addr2;
  logic [2:0] data2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] qa4[$];
  logic [2:0] qd4[$];
  logic [1:0] qa2[$];
  logic [2:0] qd2[$];

  logic [2:0] exp_d[4];

  always #5 clk = ~clk;

  prog_loader #(.BIT_WIDTH(2), .INST_WIDTH(3), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(rdy4), .wr_en(wen4), .wr_addr(addr4), .wr_data(data4),
    .cpu_hold(hold4), .done(done4)
  );

  prog_loader #(.BIT_WIDTH(2), .INST_WIDTH(3), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(rdy2), .wr_en(wen2), .wr_addr(addr2), .wr_data(data2),
    .cpu_hold(hold2), .done(done2)
  );

  // Write log, sampled away from the active edge.
  always @(negedge clk) begin
    if (wen4) begin
      qa4.push_back(addr4);
      qd4.push_back(data4);
    end
    if (wen2) begin
      qa2.push_back(addr2);
      qd2.push_back(data2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_sel();
    return sel ? rdy2 : rdy4;
  endfunction

  function automatic logic wen_sel();
    return sel ? wen2 : wen4;
  endfunction

  function automatic logic done_sel();
    return sel ? done2 : done4;
  endfunction

  task automatic pulse_start();
    if (sel) start2 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  // Present one bit and return 1 time unit after the edge that took it.
  task automatic send_bit(input logic b);
    int n;
    ser_in    = b;
    ser_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy_sel() && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", rdy_sel(), 1);
    @(posedge clk); #1;
  endtask

  // MSB first; optional one-cycle valid gap after each bit, optional start
  // pulse while the word is in flight.
  task automatic send_word(input logic [2:0] w, input bit gap, input bit busy_start);
    for (int i = 2; i >= 0; i--) begin
      if (busy_start && i == 1) start4 = 1'b1;
      send_bit(w[i]);
      start4 = 1'b0;
      if (i == 0) chk("wr_latency", wen_sel(), 1);
      if (gap) begin
        ser_valid = 1'b0;
        ser_in    = ~w[i];
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done_sel() && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", done_sel(), 1);
  endtask

  task automatic check_log4(input string tag);
    chk({tag, "_count"}, qa4.size(), 4);
    for (int i = 0; i < 4 && i < qa4.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), qa4[i], i);
      chk($sformatf("%s_data%0d", tag, i), qd4[i], exp_d[i]);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ready", rdy4, 0);
    chk("rst_wr_en", wen4, 0);
    chk("rst_done", done4, 0);
    chk("rst_hold", hold4, 1);
    chk("rst_addr", addr4, 0);
    chk("rst_data", data4, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_ignores_valid", rdy4, 0);

    // Basic load, continuous valid
    sel = 1'b0;
    pulse_start();
    chk("shift_ready", rdy4, 1);
    chk("shift_hold", hold4, 1);
    exp_d[0] = 3'b101; exp_d[1] = 3'b011; exp_d[2] = 3'b110; exp_d[3] = 3'b001;
    for (int w = 0; w < 4; w++) send_word(exp_d[w], 1'b0, 1'b0);
    ser_valid = 1'b0;
    wait_done();
    check_log4("basic");
    chk("basic_hold", hold4, 0);

    // Gapped valid, then reset two bits into the next word
    qa4.delete(); qd4.delete();
    pulse_start();
    send_word(3'b111, 1'b1, 1'b0);
    chk("gap_count", qa4.size(), 1);
    if (qa4.size() > 0) begin
      chk("gap_addr", qa4[0], 0);
      chk("gap_data", qd4[0], 3'b111);
    end
    send_bit(1'b1);
    send_bit(1'b0);
    ser_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("midrst_hold", hold4, 1);
    chk("midrst_ready", rdy4, 0);
    chk("midrst_wr_en", wen4, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_write", qa4.size(), 1);
    chk("midrst_idle", rdy4, 0);
    chk("midrst_done", done4, 0);

    // Restart after reset, with start pulsed during the addr-2 word
    qa4.delete(); qd4.delete();
    pulse_start();
    exp_d[0] = 3'b010; exp_d[1] = 3'b100; exp_d[2] = 3'b111; exp_d[3] = 3'b011;
    for (int w = 0; w < 4; w++) send_word(exp_d[w], 1'b0, w == 2);
    ser_valid = 1'b0;
    wait_done();
    check_log4("busy");

    // Reload from DONE
    qa4.delete(); qd4.delete();
    pulse_start();
    chk("reload_done", done4, 0);
    chk("reload_hold", hold4, 1);
    exp_d[0] = 3'b000; exp_d[1] = 3'b000; exp_d[2] = 3'b000; exp_d[3] = 3'b000;
    for (int w = 0; w < 4; w++) send_word(exp_d[w], 1'b0, 1'b0);
    ser_valid = 1'b0;
    wait_done();
    check_log4("reload");
    chk("reload_hold_end", hold4, 0);

    // DEPTH=2 instance
    sel = 1'b1;
    pulse_start();
    send_word(3'b110, 1'b0, 1'b0);
    send_word(3'b001, 1'b0, 1'b0);
    ser_valid = 1'b0;
    wait_done();
    repeat (4) @(posedge clk);
    #1;
    chk("d2_count", qa2.size(), 2);
    if (qa2.size() >= 2) begin
      chk("d2_addr0", qa2[0], 0);
      chk("d2_data0", qd2[0], 3'b110);
      chk("d2_addr1", qa2[1], 1);
      chk("d2_data1", qd2[1], 3'b001);
    end
    chk("d2_done", done2, 1);
    chk("d2_hold", hold2, 0);
    chk("d4_untouched", qa4.size(), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_prog_loader
